// File: rtl/ex_operand_stage.sv
// ID/EX operand register: holds one decoded instruction, resolves rs1/rs2 against MEM/WB and stalls on hazards.
// Define EX_OPERAND_FORWARD_EN to enable the MEM/WB bypass muxes; without it any in-flight match stalls.

module ex_operand_lane #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic            rs_used,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_reg_we,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_reg_we,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] value,
    output logic [XLEN-1:0] held_next,
    output logic            hazard
);
    logic nz, mem_hit, wb_hit;

    assign nz      = (rs_addr != 5'd0);
    assign mem_hit = nz && mem_reg_we && (mem_rd_addr == rs_addr);
    assign wb_hit  = nz && wb_reg_we && (wb_rd_addr == rs_addr);

    // WB write-back lands in the held copy so a stall of any length keeps the newest value
    assign held_next = wb_hit ? wb_result : rs_data;

`ifdef EX_OPERAND_FORWARD_EN
    always_comb begin
        value = rs_data;
        if (!nz)
            value = '0;
        else if (mem_hit && !mem_is_load)
            value = mem_result;
        else if (wb_hit)
            value = wb_result;
    end

    // Only a load in MEM cannot be bypassed: its data does not exist yet
    assign hazard = rs_used && mem_hit && mem_is_load;
`else
    logic unused_mem;
    assign unused_mem = ^{mem_is_load, mem_result};

    assign value  = nz ? rs_data : '0;
    assign hazard = rs_used && (mem_hit || wb_hit);
`endif
endmodule

module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    // decode side
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_sel,
    input  logic            id_src_a_pc,
    input  logic            id_src_b_imm,
    input  logic [4:0]      id_rd_addr,
    input  logic            id_reg_we,
    input  logic            id_mem_rd,
    // bypass sources
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_reg_we,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd_addr,
    input  logic            wb_reg_we,
    input  logic [XLEN-1:0] wb_result,
    // control
    input  logic            flush,
    input  logic            ex_ready,
    // ALU side
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_sel,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_we,
    output logic            ex_mem_rd
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [XLEN-1:0]              pc;
        logic [XLEN-1:0]              imm;
        logic [NUM_OPS-1:0][4:0]      rs_addr;
        logic [NUM_OPS-1:0][XLEN-1:0] rs_data;
        logic [3:0]                   alu_sel;
        logic                         src_a_pc;
        logic                         src_b_imm;
        logic [4:0]                   rd_addr;
        logic                         reg_we;
        logic                         mem_rd;
    } idex_t;

    idex_t                        held_q, incoming;
    logic                         valid_q, hazard, xfer, capture;
    logic [NUM_OPS-1:0][XLEN-1:0] rs_val, rs_next;
    logic [NUM_OPS-1:0]           rs_used, rs_haz;

    always_comb begin
        incoming            = '0;
        incoming.pc         = id_pc;
        incoming.imm        = id_imm;
        incoming.rs_addr[0] = id_rs1_addr;
        incoming.rs_addr[1] = id_rs2_addr;
        incoming.rs_data[0] = id_rs1_data;
        incoming.rs_data[1] = id_rs2_data;
        incoming.alu_sel    = id_alu_sel;
        incoming.src_a_pc   = id_src_a_pc;
        incoming.src_b_imm  = id_src_b_imm;
        incoming.rd_addr    = id_rd_addr;
        incoming.reg_we     = id_reg_we;
        incoming.mem_rd     = id_mem_rd;
    end

    // rs2 always counts: even with B = imm it may still be store data
    assign rs_used = {1'b1, ~held_q.src_a_pc};

    generate
        for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
            ex_operand_lane #(.XLEN(XLEN)) u_lane (
                .rs_addr     (held_q.rs_addr[g]),
                .rs_data     (held_q.rs_data[g]),
                .rs_used     (rs_used[g]),
                .mem_rd_addr (mem_rd_addr),
                .mem_reg_we  (mem_reg_we),
                .mem_is_load (mem_is_load),
                .mem_result  (mem_result),
                .wb_rd_addr  (wb_rd_addr),
                .wb_reg_we   (wb_reg_we),
                .wb_result   (wb_result),
                .value       (rs_val[g]),
                .held_next   (rs_next[g]),
                .hazard      (rs_haz[g])
            );
        end
    endgenerate

    assign hazard   = valid_q && (|rs_haz);
    assign ex_valid = valid_q && !hazard;
    assign xfer     = ex_valid && ex_ready;
    assign id_ready = (!valid_q || xfer) && !flush;
    assign capture  = id_valid && id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            held_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (capture) begin
            valid_q <= 1'b1;
            held_q  <= incoming;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            held_q.rs_data <= rs_next;
        end
    end

    assign alu_a         = held_q.src_a_pc  ? held_q.pc  : rs_val[0];
    assign alu_b         = held_q.src_b_imm ? held_q.imm : rs_val[1];
    assign ex_store_data = rs_val[1];
    assign alu_sel       = held_q.alu_sel;
    assign ex_pc         = held_q.pc;
    assign ex_rd_addr    = held_q.rd_addr;
    assign ex_reg_we     = held_q.reg_we;
    assign ex_mem_rd     = held_q.mem_rd;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Scenario bench for ex_operand_stage: expected ALU-side transfers are queued at issue and popped on transfer.
module tb_ex_operand_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_ready;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]      id_alu_sel;
    logic            id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_rd;
    logic [4:0]      mem_rd_addr, wb_rd_addr;
    logic            mem_reg_we, mem_is_load, wb_reg_we;
    logic [XLEN-1:0] mem_result, wb_result;
    logic            flush, ex_ready;
    logic            ex_valid, ex_reg_we, ex_mem_rd;
    logic [XLEN-1:0] alu_a, alu_b, ex_store_data, ex_pc;
    logic [3:0]      alu_sel;
    logic [4:0]      ex_rd_addr;

    ex_operand_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_sel(id_alu_sel), .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_rd_addr(id_rd_addr), .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd),
        .mem_rd_addr(mem_rd_addr), .mem_reg_we(mem_reg_we), .mem_is_load(mem_is_load),
        .mem_result(mem_result), .wb_rd_addr(wb_rd_addr), .wb_reg_we(wb_reg_we),
        .wb_result(wb_result), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr),
        .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] pc, d1, d2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic [3:0]      sel;
        logic            a_pc, b_imm, we, mrd;
    } ins_t;

    typedef struct packed {
        logic [XLEN-1:0] pc, a, b, st;
        logic [3:0]      sel;
        logic [4:0]      rd;
        logic            we, mrd;
    } exp_t;

    exp_t sb[$];
    exp_t e, g;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic ins_t mk(logic [31:0] pc, logic [4:0] rs1, logic [31:0] d1, logic [4:0] rs2,
                                logic [31:0] d2, logic [31:0] imm, logic [3:0] sel, logic a_pc,
                                logic b_imm, logic [4:0] rd, logic we, logic mrd);
        ins_t i;
        i.pc = pc; i.rs1 = rs1; i.d1 = d1; i.rs2 = rs2; i.d2 = d2; i.imm = imm; i.sel = sel;
        i.a_pc = a_pc; i.b_imm = b_imm; i.rd = rd; i.we = we; i.mrd = mrd;
        return i;
    endfunction

    // Reference operand selection with no bypass activity at transfer time
    function automatic exp_t model(ins_t i);
        exp_t x;
        logic [XLEN-1:0] r1, r2;
        r1 = (i.rs1 == 5'd0) ? '0 : i.d1;
        r2 = (i.rs2 == 5'd0) ? '0 : i.d2;
        x.pc = i.pc; x.a = i.a_pc ? i.pc : r1; x.b = i.b_imm ? i.imm : r2; x.st = r2;
        x.sel = i.sel; x.rd = i.rd; x.we = i.we; x.mrd = i.mrd;
        return x;
    endfunction

    function automatic exp_t out_now();
        return {ex_pc, alu_a, alu_b, ex_store_data, alu_sel, ex_rd_addr, ex_reg_we, ex_mem_rd};
    endfunction

    task automatic drive(input ins_t i);
        id_pc = i.pc; id_rs1_addr = i.rs1; id_rs1_data = i.d1; id_rs2_addr = i.rs2;
        id_rs2_data = i.d2; id_imm = i.imm; id_alu_sel = i.sel; id_src_a_pc = i.a_pc;
        id_src_b_imm = i.b_imm; id_rd_addr = i.rd; id_reg_we = i.we; id_mem_rd = i.mrd;
    endtask

    task automatic bus_idle();
        mem_rd_addr = 0; mem_reg_we = 0; mem_is_load = 0; mem_result = 0;
        wb_rd_addr = 0; wb_reg_we = 0; wb_result = 0;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; ex_ready = 1; id_valid = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus_idle();
        #12;
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: ex_valid=%b required 0", ex_valid);
        end
        n_cmp++;
        if ({alu_a, alu_b, ex_store_data, ex_pc} !== '0) begin
            n_bad++; $display("FAIL reset_data: a=%h b=%h st=%h pc=%h required all 0", alu_a, alu_b, ex_store_data, ex_pc);
        end
        n_cmp++;
        if ({alu_sel, ex_rd_addr, ex_reg_we, ex_mem_rd} !== '0) begin
            n_bad++; $display("FAIL reset_ctrl: sel=%h rd=%0d we=%b mrd=%b required all 0", alu_sel, ex_rd_addr, ex_reg_we, ex_mem_rd);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_basic();
        ins_t p[3];
        p[0] = mk(32'h1000, 1, 32'h1111_1111, 2, 32'h2222_2222, 32'h40, 3, 0, 0, 7, 1, 0);
        p[1] = mk(32'h1004, 3, 32'h33, 4, 32'h44, 32'hFFFF_FFF0, 5, 1, 1, 8, 1, 0);
        p[2] = mk(32'h1008, 9, 32'h99, 10, 32'hAA, 32'h8, 0, 0, 1, 0, 0, 1);
        ex_ready = 1;
        @(posedge clk); #1;
        drive(p[0]); id_valid = 1; sb.push_back(model(p[0]));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i < 2) begin drive(p[i+1]); sb.push_back(model(p[i+1])); end
            else id_valid = 0;
            @(negedge clk);
            n_cmp++;
            if (!(ex_valid && ex_ready) || sb.size() == 0) begin
                n_bad++; $display("FAIL basic_xfer: ex_valid=%b queued=%0d, required a transfer", ex_valid, sb.size());
            end else begin
                e = sb.pop_front(); g = out_now();
                if (g !== e) begin n_bad++; $display("FAIL basic_data: got %h required %h", g, e); end
            end
        end
        @(negedge clk);
        n_cmp++;
        if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL basic_drain: ex_valid=%b required 0", ex_valid); end
    endtask

    task automatic test_forward();
        ins_t i;
        i = mk(32'h2000, 5, 32'h10, 6, 32'h20, 0, 1, 0, 0, 11, 1, 0);
        ex_ready = 0;
        @(posedge clk); #1;
        drive(i); id_valid = 1;
        @(posedge clk); #1;
        id_valid = 0;
        mem_reg_we = 1; mem_rd_addr = 5; mem_result = 32'h99; mem_is_load = 0;
        wb_reg_we = 1; wb_rd_addr = 5; wb_result = 32'h77;
        @(negedge clk);
        n_cmp++;
`ifdef EX_OPERAND_FORWARD_EN
        if (ex_valid !== 1'b1 || alu_a !== 32'h99) begin
            n_bad++; $display("FAIL fwd_mem_priority: ex_valid=%b alu_a=%h required 1 / 00000099", ex_valid, alu_a);
        end
`else
        if (ex_valid !== 1'b0) begin
            n_bad++; $display("FAIL nofwd_hazard: ex_valid=%b required 0", ex_valid);
        end
`endif
        // this edge refreshes the held rs1 copy from WB
        @(posedge clk); #1;
        bus_idle(); ex_ready = 1;
        e = model(i); e.a = 32'h77; sb.push_back(e);
        @(negedge clk);
        n_cmp++;
        if (!(ex_valid && ex_ready) || sb.size() == 0) begin
            n_bad++; $display("FAIL fwd_refresh_xfer: ex_valid=%b queued=%0d, required a transfer", ex_valid, sb.size());
        end else begin
            e = sb.pop_front(); g = out_now();
            if (g !== e) begin n_bad++; $display("FAIL fwd_refresh_data: got %h required %h", g, e); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        ins_t i;
        i = mk(32'h3000, 1, 32'h11, 3, 32'h33, 32'h4, 2, 0, 1, 12, 0, 0);
        ex_ready = 1;
        @(posedge clk); #1;
        drive(i); id_valid = 1;
        e = model(i); e.st = 32'hABCD; sb.push_back(e);
        @(posedge clk); #1;
        id_valid = 0;
        mem_reg_we = 1; mem_rd_addr = 3; mem_is_load = 1; mem_result = 32'hDEAD;
        @(negedge clk);
        n_cmp++;
        if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin
            n_bad++; $display("FAIL lu_stall: ex_valid=%b id_ready=%b required 0/0", ex_valid, id_ready);
        end
        @(posedge clk); #1;
        bus_idle();
        wb_reg_we = 1; wb_rd_addr = 3; wb_result = 32'hABCD;
`ifndef EX_OPERAND_FORWARD_EN
        @(negedge clk);
        n_cmp++;
        if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL lu_wb_hazard: ex_valid=%b required 0", ex_valid); end
        @(posedge clk); #1;
        bus_idle();
`endif
        @(negedge clk);
        n_cmp++;
        if (!(ex_valid && ex_ready) || sb.size() == 0) begin
            n_bad++; $display("FAIL lu_xfer: ex_valid=%b queued=%0d, required a transfer", ex_valid, sb.size());
        end else begin
            e = sb.pop_front(); g = out_now();
            if (g !== e) begin n_bad++; $display("FAIL lu_data: got %h required %h", g, e); end
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic test_x0();
        ins_t i;
        i = mk(32'h4000, 0, 32'h1234, 4, 32'h44, 0, 6, 0, 0, 13, 1, 0);
        ex_ready = 1;
        @(posedge clk); #1;
        drive(i); id_valid = 1; sb.push_back(model(i));
        mem_reg_we = 1; mem_rd_addr = 0; mem_result = 32'hFFFF; mem_is_load = 0;
        wb_reg_we = 1; wb_rd_addr = 0; wb_result = 32'h5555;
        @(posedge clk); #1;
        id_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (!(ex_valid && ex_ready) || sb.size() == 0) begin
            n_bad++; $display("FAIL x0_xfer: ex_valid=%b queued=%0d, required a transfer", ex_valid, sb.size());
        end else begin
            e = sb.pop_front(); g = out_now();
            if (g !== e) begin n_bad++; $display("FAIL x0_data: got %h required %h", g, e); end
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic test_flush();
        ex_ready = 0;
        @(posedge clk); #1;
        drive(mk(32'h5000, 1, 1, 2, 2, 0, 1, 0, 0, 1, 1, 0)); id_valid = 1;
        @(posedge clk); #1;
        drive(mk(32'h5100, 3, 3, 4, 4, 0, 2, 0, 0, 2, 1, 0)); id_valid = 1; flush = 1;
        @(negedge clk);
        n_cmp++;
        if (id_ready !== 1'b0) begin n_bad++; $display("FAIL flush_id_ready: id_ready=%b required 0", id_ready); end
        @(posedge clk); #1;
        flush = 0; id_valid = 0; ex_ready = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ex_valid !== 1'b0) begin
                n_bad++; $display("FAIL flush_killed: cycle %0d ex_valid=%b pc=%h required 0", k, ex_valid, ex_pc);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        ins_t p[3];
        p[0] = mk(32'h7000, 1, 32'hA1, 2, 32'hB2, 32'h10, 4, 0, 0, 3, 1, 0);
        p[1] = mk(32'h7004, 5, 32'hC3, 6, 32'hD4, 32'h20, 7, 0, 1, 4, 1, 1);
        p[2] = mk(32'h7008, 7, 32'hE5, 8, 32'hF6, 32'h30, 9, 1, 0, 5, 0, 0);
        ex_ready = 0;
        @(posedge clk); #1;
        drive(p[0]); id_valid = 1; sb.push_back(model(p[0]));
        @(posedge clk); #1;
        drive(p[1]); sb.push_back(model(p[1]));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (id_ready !== 1'b0 || ex_valid !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold: cycle %0d id_ready=%b ex_valid=%b required 0/1", k, id_ready, ex_valid);
            end
            @(posedge clk);
        end
        #1 ex_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (!(ex_valid && ex_ready) || sb.size() == 0) begin
                n_bad++; $display("FAIL b2b_xfer: slot %0d ex_valid=%b queued=%0d, required a transfer", k, ex_valid, sb.size());
            end else begin
                e = sb.pop_front(); g = out_now();
                if (g !== e) begin n_bad++; $display("FAIL b2b_data: slot %0d got %h required %h", k, g, e); end
            end
            @(posedge clk); #1;
            if (k == 0) begin drive(p[2]); sb.push_back(model(p[2])); end
            else id_valid = 0;
        end
        @(negedge clk);
        n_cmp++;
        if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: ex_valid=%b required 0", ex_valid); end
    endtask

    task automatic test_rst_midstall();
        ins_t i;
        ex_ready = 0;
        @(posedge clk); #1;
        drive(mk(32'h6000, 1, 32'h1, 2, 32'h2, 0, 9, 1, 0, 14, 1, 1)); id_valid = 1;
        @(posedge clk); #1;
        id_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (ex_valid !== 1'b1 || alu_a !== 32'h6000) begin
            n_bad++; $display("FAIL rst_pre: ex_valid=%b alu_a=%h required 1 / 00006000", ex_valid, alu_a);
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (ex_valid !== 1'b0 || alu_a !== '0) begin
            n_bad++; $display("FAIL rst_async: ex_valid=%b alu_a=%h required 0 / 0", ex_valid, alu_a);
        end
        n_cmp++;
        if ({ex_pc, alu_sel, ex_rd_addr, ex_reg_we, ex_mem_rd} !== '0) begin
            n_bad++; $display("FAIL rst_async_ctrl: pc=%h sel=%h rd=%0d we=%b mrd=%b required all 0", ex_pc, alu_sel, ex_rd_addr, ex_reg_we, ex_mem_rd);
        end
        @(posedge clk); #1;
        rst = 0; ex_ready = 1;
        i = mk(32'h6100, 2, 32'h222, 3, 32'h333, 32'h5, 1, 0, 1, 15, 1, 0);
        drive(i); id_valid = 1; sb.push_back(model(i));
        @(posedge clk); #1;
        id_valid = 0;
        @(negedge clk);
        n_cmp++;
        if (!(ex_valid && ex_ready) || sb.size() == 0) begin
            n_bad++; $display("FAIL rst_recover_xfer: ex_valid=%b queued=%0d, required a transfer", ex_valid, sb.size());
        end else begin
            e = sb.pop_front(); g = out_now();
            if (g !== e) begin n_bad++; $display("FAIL rst_recover_data: got %h required %h", g, e); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_load_use();
        test_x0();
        test_flush();
        test_back_to_back();
        test_rst_midstall();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: %0d entries remain, required 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
